// File: rtl/databus_mem_responder_pkg.sv
// Shared definitions for the databus memory responder: FSM encoding, byte-offset
// helper and the idle-timeout limit used when DBUS_RESP_TIMEOUT_EN is defined.
package databus_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int TIMEOUT_LIMIT = 255;

    // Number of low address bits that select a byte within one databus word.
    function automatic int boff(input int databus_w);
        return $clog2(databus_w / 8);
    endfunction

endpackage

// File: rtl/databus_mem_responder_if.sv
// Versat databus bundle between N_PORTS master channels and the memory responder,
// plus the responder's arbitration status (grant/busy/timeout).
interface databus_mem_responder_if #(
    parameter int N_PORTS   = 3,
    parameter int ADDR_W    = 32,
    parameter int DATABUS_W = 256,
    parameter int AXI_LEN_W = 8
);
    logic [N_PORTS-1:0]             databus_valid;
    logic [N_PORTS*ADDR_W-1:0]      databus_addr;
    logic [N_PORTS*DATABUS_W-1:0]   databus_wdata;
    logic [N_PORTS*DATABUS_W/8-1:0] databus_wstrb;
    logic [AXI_LEN_W-1:0]           dma_len;
    logic [N_PORTS-1:0]             databus_ready;
    logic [N_PORTS*DATABUS_W-1:0]   databus_rdata;
    logic [N_PORTS-1:0]             grant;
    logic                           busy;
    logic                           timeout;

    modport master (
        output databus_valid, databus_addr, databus_wdata, databus_wstrb, dma_len,
        input  databus_ready, databus_rdata, grant, busy, timeout
    );

    modport slave (
        input  databus_valid, databus_addr, databus_wdata, databus_wstrb, dma_len,
        output databus_ready, databus_rdata, grant, busy, timeout
    );
endinterface

// File: rtl/databus_mem_responder_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the last-grant
// index, wrapping, returned both one-hot and as an index.
module databus_mem_responder_rr_arbiter #(
    parameter int N_PORTS = 3,
    parameter int PTR_W   = 2
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_last,
    output logic [N_PORTS-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx
);
    int w_j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = i_last;
        w_j     = 0;
        for (int k = N_PORTS; k >= 1; k--) begin
            w_j = (int'(i_last) + k) % N_PORTS;
            if (i_req[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = PTR_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/databus_mem_responder.sv
// On-chip memory responder for the Versat databus: round-robin burst arbitration
// over N_PORTS masters. Optional idle timeout in BEAT via `define DBUS_RESP_TIMEOUT_EN.
module databus_mem_responder
    import databus_mem_responder_pkg::*;
#(
    parameter int N_PORTS    = 3,
    parameter int ADDR_W     = 32,
    parameter int DATABUS_W  = 256,
    parameter int MEM_ADDR_W = 10,
    parameter int AXI_LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    databus_mem_responder_if.slave bus
);
    localparam int BOFF  = boff(DATABUS_W);
    localparam int SW    = DATABUS_W / 8;
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = 1 << MEM_ADDR_W;

    state_e                 r_state, w_state_nxt;
    logic [N_PORTS-1:0]     r_grant, w_grant_nxt, w_arb_grant;
    logic [PTR_W-1:0]       r_gidx, w_gidx_nxt, w_arb_idx;
    logic [AXI_LEN_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DATABUS_W-1:0]   r_rdata;
    logic [DATABUS_W-1:0]   r_mem [DEPTH];
    logic                   w_vld, w_wr, w_rd, w_timeout;
    logic [MEM_ADDR_W-1:0]  w_word;
    logic [SW-1:0]          w_wstrb;
    logic [DATABUS_W-1:0]   w_wdata;
`ifdef DBUS_RESP_TIMEOUT_EN
    logic [7:0]             r_idle, w_idle_nxt;
`endif

    databus_mem_responder_rr_arbiter #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_arb (
        .i_req   (bus.databus_valid),
        .i_last  (r_gidx),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // Only the granted port's channel is ever looked at; upper address bits alias.
    assign w_vld   = bus.databus_valid[r_gidx];
    assign w_word  = bus.databus_addr[int'(r_gidx)*ADDR_W + BOFF +: MEM_ADDR_W];
    assign w_wstrb = bus.databus_wstrb[int'(r_gidx)*SW +: SW];
    assign w_wdata = bus.databus_wdata[int'(r_gidx)*DATABUS_W +: DATABUS_W];
    assign w_wr    = (r_state == ST_BEAT) && w_vld && (|w_wstrb);
    assign w_rd    = (r_state == ST_BEAT) && w_vld && !(|w_wstrb);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
`ifdef DBUS_RESP_TIMEOUT_EN
        w_idle_nxt  = 8'd0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|bus.databus_valid) begin
                    w_grant_nxt = w_arb_grant;
                    w_gidx_nxt  = w_arb_idx;
                    w_cnt_nxt   = bus.dma_len;
                    w_state_nxt = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (w_vld) begin
                    w_state_nxt = ST_ACK;
                end
`ifdef DBUS_RESP_TIMEOUT_EN
                else if (r_idle == 8'(TIMEOUT_LIMIT)) begin
                    w_timeout   = 1'b1;
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idle_nxt  = r_idle + 8'd1;
                end
`endif
            end
            ST_ACK: begin
                if (r_cnt == '0) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - AXI_LEN_W'(1);
                    w_state_nxt = ST_BEAT;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= PTR_W'(N_PORTS - 1);
            r_cnt   <= '0;
`ifdef DBUS_RESP_TIMEOUT_EN
            r_idle  <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef DBUS_RESP_TIMEOUT_EN
            r_idle  <= w_idle_nxt;
`endif
        end
    end

    // Contents survive reset; only the FSM gates the write enable.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < SW; b++) begin
                if (w_wstrb[b]) r_mem[w_word][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rdata <= '0;
        else if (w_rd) r_rdata <= r_mem[w_word];
    end

    always_comb begin
        bus.databus_ready = '0;
        bus.databus_rdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_state == ST_ACK && r_grant[i]) begin
                bus.databus_ready[i]                      = 1'b1;
                bus.databus_rdata[i*DATABUS_W +: DATABUS_W] = r_rdata;
            end
        end
    end

    assign bus.grant   = r_grant;
    assign bus.busy    = |r_grant;
    assign bus.timeout = w_timeout;
endmodule

// File: tb/tb_databus_mem_responder.sv
// Directed-vector bench for databus_mem_responder; expected values are hand-computed
// constants. Timeout section follows DBUS_RESP_TIMEOUT_EN.
module tb_databus_mem_responder;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;

    databus_mem_responder_if #(.N_PORTS(NP), .ADDR_W(AW), .DATABUS_W(DW), .AXI_LEN_W(LW)) bus ();

    databus_mem_responder #(
        .N_PORTS(NP), .ADDR_W(AW), .DATABUS_W(DW), .MEM_ADDR_W(10), .AXI_LEN_W(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] wr_q [4];
    logic [DW-1:0] rd_q [4];
    int            lat_q [4];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.databus_valid[p]          = v;
        bus.databus_addr[p*AW +: AW]  = a;
        bus.databus_wdata[p*DW +: DW] = d;
        bus.databus_wstrb[p*SW +: SW] = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) drive(p, 1'b0, '0, '0, '0);
        bus.dma_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for ready on port p; also checks no other port is acknowledged.
    task automatic wait_ready(input int p, input string tag, output int cyc);
        logic          hit;
        logic [NP-1:0] m;
        hit = 1'b0;
        cyc = 0;
        m   = NP'(1) << p;
        while (!hit && cyc < 40) begin
            @(negedge clk);
            cyc++;
            hit = bus.databus_ready[p];
        end
        chk({tag, "_rdy"}, DW'(hit), DW'(1));
        chk({tag, "_onehot"}, DW'(bus.databus_ready), DW'(m));
    endtask

    task automatic burst(input int p, input logic [AW-1:0] base, input int nb, input bit wr,
                         input logic [SW-1:0] strb, input bit mangle_len, input string tag);
        @(posedge clk);
        #1;
        bus.dma_len = LW'(nb - 1);
        for (int k = 0; k < nb; k++) begin
            drive(p, 1'b1, base + AW'(32 * k), wr ? wr_q[k] : '0, wr ? strb : '0);
            wait_ready(p, tag, lat_q[k]);
            rd_q[k] = bus.databus_rdata[p*DW +: DW];
            if (mangle_len && k == 0) bus.dma_len = '0;
            @(posedge clk);
            #1;
        end
        drive(p, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int            c;
        int            nr;
        int            ord [4];
        logic [NP-1:0] any_rdy;
        logic          seen;

        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", DW'(bus.databus_ready), '0);
        chk("rst_grant", DW'(bus.grant), '0);
        chk("rst_busy", DW'(bus.busy), '0);
        chk("rst_timeout", DW'(bus.timeout), '0);
        chk("rst_rdata", bus.databus_rdata[DW-1:0], '0);
        @(negedge clk);
        rst = 1'b0;

        // Single-beat write then read on port 1.
        wr_q[0] = 256'hA5;
        burst(1, 32'h40, 1, 1'b1, '1, 1'b0, "t1w");
        chk("t1_wr_lat", DW'(lat_q[0]), DW'(3));
        burst(1, 32'h40, 1, 1'b0, '0, 1'b0, "t1r");
        chk("t1_rd_lat", DW'(lat_q[0]), DW'(3));
        chk("t1_rd_data", rd_q[0], 256'hA5);

        // Port 2 fills words 0..3, port 0 reads them back in one 4-beat burst.
        wr_q[0] = {8{32'h1111_0001}};
        wr_q[1] = {8{32'h2222_0002}};
        wr_q[2] = {8{32'h3333_0003}};
        wr_q[3] = {8{32'h4444_0004}};
        burst(2, 32'h0, 4, 1'b1, '1, 1'b0, "t2w");
        burst(0, 32'h0, 4, 1'b0, '0, 1'b1, "t2r");
        chk("t2_lat0", DW'(lat_q[0]), DW'(3));
        chk("t2_d0", rd_q[0], {8{32'h1111_0001}});
        chk("t2_lat1", DW'(lat_q[1]), DW'(2));
        chk("t2_d1", rd_q[1], {8{32'h2222_0002}});
        chk("t2_lat2", DW'(lat_q[2]), DW'(2));
        chk("t2_d2", rd_q[2], {8{32'h3333_0003}});
        chk("t2_lat3", DW'(lat_q[3]), DW'(2));
        chk("t2_d3", rd_q[3], {8{32'h4444_0004}});
        @(negedge clk);
        chk("t2_grant_off", DW'(bus.grant), '0);
        chk("t2_busy_off", DW'(bus.busy), '0);
        any_rdy = '0;
        repeat (4) begin
            @(negedge clk);
            any_rdy |= bus.databus_ready;
        end
        chk("t2_no_extra_rdy", DW'(any_rdy), '0);

        // Byte strobe: only byte 0 of an all-ones write lands; aliased read address.
        wr_q[0] = '0;
        burst(2, 32'hA0, 1, 1'b1, '1, 1'b0, "t3z");
        wr_q[0] = '1;
        burst(2, 32'hA0, 1, 1'b1, 32'h1, 1'b0, "t3s");
        burst(1, 32'hA0, 1, 1'b0, '0, 1'b0, "t3r");
        chk("t3_strobe", rd_q[0], 256'hFF);
        burst(1, 32'h8000_80A0, 1, 1'b0, '0, 1'b0, "t3a");
        chk("t3_alias", rd_q[0], 256'hFF);

        // Reset in the 2nd beat of a 4-beat write burst.
        for (int k = 0; k < 4; k++) wr_q[k] = {8{32'hDEAD_0000}};
        burst(0, 32'h100, 4, 1'b1, '1, 1'b0, "t4p");
        @(posedge clk);
        #1;
        bus.dma_len = LW'(3);
        drive(0, 1'b1, 32'h100, {8{32'hBEEF_0000}}, '1);
        wait_ready(0, "t4b0", c);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 32'h120, {8{32'hBEEF_0000}}, '1);
        #3;
        rst = 1'b1;
        #1;
        chk("t4_ready", DW'(bus.databus_ready), '0);
        chk("t4_grant", DW'(bus.grant), '0);
        chk("t4_busy", DW'(bus.busy), '0);
        chk("t4_rdata", bus.databus_rdata[DW-1:0], '0);
        drive(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        burst(1, 32'h100, 4, 1'b0, '0, 1'b0, "t4r");
        chk("t4_w8", rd_q[0], {8{32'hBEEF_0000}});
        chk("t4_w9", rd_q[1], {8{32'hDEAD_0000}});
        chk("t4_w10", rd_q[2], {8{32'hDEAD_0000}});
        chk("t4_w11", rd_q[3], {8{32'hDEAD_0000}});

        // All three ports request single beats from reset: order 0,1,2,0.
        do_reset();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 32'h0, '0, '0);
        nr = 0;
        for (int k = 0; k < 4; k++) ord[k] = -1;
        repeat (13) begin
            @(negedge clk);
            if (|bus.databus_ready) begin
                chk("rr_rdy_eq_grant", DW'(bus.databus_ready), DW'(bus.grant));
                if (nr < 4) begin
                    for (int p = 0; p < NP; p++) if (bus.databus_ready[p]) ord[nr] = p;
                end
                nr++;
            end
        end
        chk("rr_count", DW'(nr), DW'(4));
        chk("rr_ord0", DW'(ord[0]), DW'(0));
        chk("rr_ord1", DW'(ord[1]), DW'(1));
        chk("rr_ord2", DW'(ord[2]), DW'(2));
        chk("rr_ord3", DW'(ord[3]), DW'(0));
        do_reset();

        // Granted port 2 goes quiet in BEAT.
        @(posedge clk);
        #1;
        drive(2, 1'b1, 32'h40, '0, '0);
        c = 0;
        while (!bus.grant[2] && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("to_grant", DW'(bus.grant), DW'(3'b100));
        drive(2, 1'b0, '0, '0, '0);
`ifdef DBUS_RESP_TIMEOUT_EN
        c = 0;
        while (!bus.timeout && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("to_cycles", DW'(c), DW'(255));
        @(negedge clk);
        chk("to_grant_off", DW'(bus.grant), '0);
        chk("to_pulse_1cyc", DW'(bus.timeout), '0);
`else
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            seen |= bus.timeout;
        end
        chk("hold_grant", DW'(bus.grant), DW'(3'b100));
        chk("hold_busy", DW'(bus.busy), DW'(1));
        chk("hold_no_timeout", DW'(seen), '0);
`endif
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/databus_mem_responder.md
Name: databus_mem_responder

Overview:
- Responder (slave) end of the Versat databus: serves N_PORTS databus master channels, e.g. the xyolo read FU (port 0) and the xyolo write FU (ports 1-2).
- Backed by an on-chip word-wide memory.
- Round-robin arbitration; a granted port keeps the bus for a whole burst of dma_len+1 beats.
- Used as the simulation/on-chip memory endpoint in place of the external DMA path.

Parameters:
- N_PORTS, 3, number of databus master channels.
- ADDR_W, 32, databus byte-address width.
- DATABUS_W, 256, data width per beat (bits).
- MEM_ADDR_W, 10, memory depth as log2 of number of DATABUS_W words.
- AXI_LEN_W, 8, burst-length field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- databus_valid  in  N_PORTS  per-port request.
- databus_addr  in  N_PORTS*ADDR_W  per-port byte address; port i in slice [i*ADDR_W +: ADDR_W].
- databus_wdata  in  N_PORTS*DATABUS_W  per-port write data.
- databus_wstrb  in  N_PORTS*DATABUS_W/8  per-port byte strobes; all-zero means read.
- dma_len  in  AXI_LEN_W  beats-1 of the burst; sampled at grant.
- databus_ready  out  N_PORTS  one-cycle per-beat acknowledge.
- databus_rdata  out  N_PORTS*DATABUS_W  read data; valid only while the matching ready is high.
- grant  out  N_PORTS  one-hot current owner; 0 when idle.
- busy  out  1  high whenever grant != 0.
- timeout  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = IDLE, beat counter 0.
  - Last-grant pointer = N_PORTS-1, so port 0 wins the first arbitration.
  - Memory contents are not reset.
- Word index = addr[BOFF+MEM_ADDR_W-1 : BOFF], where BOFF = log2(DATABUS_W/8). Upper bits are ignored, so addresses alias modulo the memory size.
- IDLE:
  - If any valid is high, grant the first requesting port after the last-grant pointer (round-robin).
  - Update the pointer, set grant, load cnt = dma_len, go to BEAT.
- BEAT:
  - If valid[g] is high and wstrb[g] != 0: write the enabled bytes of wdata[g] to mem[word].
  - If valid[g] is high and wstrb[g] == 0: read mem[word] into the rdata register.
  - Either access goes to ACK.
  - If valid[g] is low: stay in BEAT, grant held.
- ACK:
  - ready[g] = 1 for exactly this cycle.
  - rdata[g] holds the read word (writes leave it unchanged); other ports' rdata = 0.
  - If cnt == 0, clear grant and go to IDLE; otherwise cnt <= cnt-1 and go to BEAT.
- Latency: valid sampled in IDLE at cycle t → grant at t+1 → ready at t+2. Subsequent beats take 2 cycles each. Minimum idle gap between bursts is 1 cycle.
- The master must present the next beat (or drop valid) in the cycle after ready. A valid still high in BEAT is always treated as a new beat.
- Requests from non-granted ports are ignored and never acknowledged until they are granted. dma_len changes mid-burst have no effect.
- dma_len = 0 gives a single-beat burst. dma_len = 2^AXI_LEN_W-1 gives 2^AXI_LEN_W beats; the counter never wraps.
- If all ports request simultaneously, grants rotate 0,1,2,0…
- Read-after-write to the same word in consecutive beats returns the new data.
- An asynchronous rst mid-burst returns the block immediately to reset values. A partial burst is abandoned; words already written remain written.

Optional Feature:
- Macro DBUS_RESP_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter runs while in BEAT with valid[g] low.
  - When it reaches 255, grant is released, FSM goes to IDLE, and timeout pulses 1 cycle.
  - The counter clears on every beat.
- Not defined: BEAT waits indefinitely; timeout is tied 0.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (IDLE=0, BEAT=1, ACK=2).
  - BOFF = log2(DATABUS_W/8).
  - Timeout limit constant 255.
- Natural sub-module: rr_arbiter (N_PORTS requests, last-grant pointer in, one-hot grant out; purely combinational next-grant).
- Memory inferred inline as byte-enabled RAM.

Test Plan:
- Port 1 writes 0xA5 (all strobes) to addr 0x40 with dma_len=0, then reads 0x40 → ready at +2 cycles each; read rdata[1] = 0xA5 zero-extended.
- Port 0 burst, dma_len=3, reads addrs 0x0,0x20,0x40,0x60 → exactly 4 ready pulses, 2 cycles apart; grant drops after the 4th; busy = 0 the next cycle.
- Ports 0,1,2 all request with dma_len=0 held high → grant order 0,1,2,0; no ready on a non-granted port.
- Write strobes 0x00000001 with data all-ones over a word of zeros → readback byte 0 = 0xFF, all other bytes 0.
- Assert rst during the 2nd beat of a 4-beat write burst → all outputs 0 the same cycle; the first-beat word is written, the 2nd–4th beat words are unchanged.
- With DBUS_RESP_TIMEOUT_EN: grant port 2, drop valid → timeout pulse after 255 idle cycles, grant = 0. Without the macro: grant is still held after 1000 cycles.
